// File: rtl/decoder_pkg.sv
// decoder_pkg: shared state encoding and mode constants for the decoder_scan family.
// Contents:
//   state_e      - IDLE / DIRECT / SCAN controller states
//   MODE_DIRECT  - mode input value selecting direct decode
//   MODE_SCAN    - mode input value selecting channel scan
package decoder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_e;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/decoder_onehot.sv
// decoder_onehot: combinational SEL_W-to-NUM_OUT one-hot decode, zero for out-of-range codes.
// Ports:
//   sel_i  [SEL_W-1:0]    select code
//   out_o  [NUM_OUT-1:0]  one-hot decode of sel_i, all zero when sel_i >= NUM_OUT
module decoder_onehot #(
    parameter int SEL_W   = 2,
    parameter int NUM_OUT = 4
) (
    input  logic [SEL_W-1:0]   sel_i,
    output logic [NUM_OUT-1:0] out_o
);

    assign out_o = (32'(sel_i) < NUM_OUT) ? (NUM_OUT'(1) << sel_i) : '0;

endmodule

// File: rtl/decoder_scan.sv
// decoder_scan: registered binary-to-one-hot decoder with direct and dwell-timed scan modes.
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous active-high reset
//   en       block enable; low forces IDLE and zero outputs next cycle
//   mode     0 = direct, 1 = scan; used on load
//   load     one-cycle strobe: capture sel_in (direct) or start scan
//   sel_in   select code
//   dec_out  registered one-hot (or zero) output
//   sel_cur  code currently driven on dec_out
//   step     one-cycle pulse when the scan advances
//   busy     high in DIRECT or SCAN
//   err      (only with DECODER_SCAN_ERR_EN) pulses the cycle after a load of an out-of-range code
// Build option: define DECODER_SCAN_ERR_EN to add the err output.
module decoder_scan
    import decoder_pkg::*;
#(
    parameter int SEL_W   = 2,
    parameter int NUM_OUT = 4,
    parameter int DWELL   = 4,
    parameter int CNT_W   = $clog2(DWELL + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               mode,
    input  logic               load,
    input  logic [SEL_W-1:0]   sel_in,
    output logic [NUM_OUT-1:0] dec_out,
    output logic [SEL_W-1:0]   sel_cur,
    output logic               step,
    output logic               busy
`ifdef DECODER_SCAN_ERR_EN
    ,
    output logic               err
`endif
);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_OUT-1:0] dec_q, dec_d, onehot;
    logic               step_q, step_d;
    logic               busy_q, busy_d;
    logic               in_range, dwell_done;
    logic [SEL_W-1:0]   sel_next;

    assign in_range   = 32'(sel_in) < NUM_OUT;
    assign dwell_done = cnt_q == CNT_W'(DWELL - 1);
    // Wrap at NUM_OUT-1 explicitly; codes above it are never scanned.
    assign sel_next   = (sel_q == SEL_W'(NUM_OUT - 1)) ? '0 : sel_q + SEL_W'(1);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        step_d  = 1'b0;
        if (!en) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (load) begin
            state_d = (mode == MODE_DIRECT) ? DIRECT : SCAN;
            sel_d   = (mode == MODE_DIRECT || in_range) ? sel_in : '0;
            cnt_d   = '0;
        end else if (state_q == SCAN) begin
            cnt_d  = dwell_done ? '0 : cnt_q + CNT_W'(1);
            step_d = dwell_done;
            sel_d  = dwell_done ? sel_next : sel_q;
        end
        busy_d = state_d != IDLE;
        // Decoding the next code keeps dec_out aligned with sel_cur and never multi-hot.
        dec_d  = busy_d ? onehot : '0;
    end

    decoder_onehot #(
        .SEL_W   (SEL_W),
        .NUM_OUT (NUM_OUT)
    ) u_onehot (
        .sel_i (sel_d),
        .out_o (onehot)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
            dec_q   <= '0;
            step_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            dec_q   <= dec_d;
            step_q  <= step_d;
            busy_q  <= busy_d;
        end
    end

    assign dec_out = dec_q;
    assign sel_cur = sel_q;
    assign step    = step_q;
    assign busy    = busy_q;

`ifdef DECODER_SCAN_ERR_EN
    logic err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= en & load & ~in_range;
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_decoder_scan.sv
// tb_decoder_scan: two decoder_scan instances (3/5/3 and 2/4/1) under directed and random stimulus.
module tb_decoder_scan;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0, load = 1'b0, mode = 1'b0;
    logic [2:0] sel = '0;

    logic [4:0] dec_a;
    logic [2:0] cur_a;
    logic       step_a, busy_a;
    logic [3:0] dec_b;
    logic [1:0] cur_b;
    logic       step_b, busy_b;
`ifdef DECODER_SCAN_ERR_EN
    logic       err_a, err_b;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    decoder_scan #(.SEL_W(3), .NUM_OUT(5), .DWELL(3)) ua (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .sel_in(sel),
        .dec_out(dec_a), .sel_cur(cur_a), .step(step_a), .busy(busy_a)
`ifdef DECODER_SCAN_ERR_EN
        , .err(err_a)
`endif
    );

    decoder_scan #(.SEL_W(2), .NUM_OUT(4), .DWELL(1)) ub (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .sel_in(sel[1:0]),
        .dec_out(dec_b), .sel_cur(cur_b), .step(step_b), .busy(busy_b)
`ifdef DECODER_SCAN_ERR_EN
        , .err(err_b)
`endif
    );

    // Reference: st 0 idle, 1 direct, 2 scan; cnt counts cycles spent on the current channel.
    typedef struct {
        int st;
        int sel;
        int cnt;
        bit step;
        bit err;
    } mst_t;

    mst_t ma = '{default: 0};
    mst_t mb = '{default: 0};

    function automatic mst_t nxt(mst_t m, bit e, bit l, bit md, int s, int n, int d);
        mst_t r = m;
        r.step = 0;
        r.err  = 0;
        if (!e) begin
            r.st  = 0;
            r.cnt = 0;
        end else if (l) begin
            r.err = s >= n;
            r.cnt = 0;
            r.st  = md ? 2 : 1;
            r.sel = (md && s >= n) ? 0 : s;
        end else if (m.st == 2) begin
            r.cnt = m.cnt + 1;
            if (r.cnt == d) begin
                r.cnt  = 0;
                r.step = 1;
                r.sel  = (m.sel + 1) % n;
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] edec(mst_t m, int n);
        return (m.st != 0 && m.sel < n) ? 32'(1) << m.sel : 32'd0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ma <= '{default: 0};
            mb <= '{default: 0};
        end else begin
            ma <= nxt(ma, en, load, mode, int'(sel), 5, 3);
            mb <= nxt(mb, en, load, mode, int'(sel[1:0]), 4, 1);
        end
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t act=%0h exp=%0h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("a_dec", 32'(dec_a), edec(ma, 5));
        chk("a_sel", 32'(cur_a), 32'(ma.sel));
        chk("a_step", 32'(step_a), 32'(ma.step));
        chk("a_busy", 32'(busy_a), 32'(ma.st != 0));
        chk("a_onehot0", 32'($onehot0(dec_a)), 32'd1);
        chk("b_dec", 32'(dec_b), edec(mb, 4));
        chk("b_sel", 32'(cur_b), 32'(mb.sel));
        chk("b_step", 32'(step_b), 32'(mb.step));
        chk("b_busy", 32'(busy_b), 32'(mb.st != 0));
        chk("b_onehot0", 32'($onehot0(dec_b)), 32'd1);
`ifdef DECODER_SCAN_ERR_EN
        chk("a_err", 32'(err_a), 32'(ma.err));
        chk("b_err", 32'(err_b), 32'(mb.err));
`endif
    end

    task automatic drv(bit e, bit l, bit m, logic [2:0] s);
        en   = e;
        load = l;
        mode = m;
        sel  = s;
        @(negedge clk);
        #1;
    endtask

    task automatic idle(int k);
        for (int i = 0; i < k; i++) drv(1, 0, 0, 3'd0);
    endtask

    initial begin
        #1 rst = 1'b1;
        drv(0, 0, 0, 3'd0);
        drv(0, 0, 0, 3'd0);
        rst = 1'b0;
        drv(0, 0, 0, 3'd0);
        chk("rst_dec", 32'(dec_a), 32'd0);
        chk("rst_sel", 32'(cur_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_step", 32'(step_a), 32'd0);

        drv(1, 1, 0, 3'd2);
        chk("dir_dec_a", 32'(dec_a), 32'h04);
        chk("dir_sel_a", 32'(cur_a), 32'd2);
        chk("dir_busy_a", 32'(busy_a), 32'd1);
        chk("dir_dec_b", 32'(dec_b), 32'h4);

        drv(1, 1, 1, 3'd3);
        chk("scan0_dec_a", 32'(dec_a), 32'h08);
        chk("scan0_step_a", 32'(step_a), 32'd0);
        chk("scan0_dec_b", 32'(dec_b), 32'h8);
        idle(1);
        chk("d1_dec_b", 32'(dec_b), 32'h1);
        chk("d1_step_b", 32'(step_b), 32'd1);
        idle(1);
        chk("scan2_dec_a", 32'(dec_a), 32'h08);
        chk("d1_dec_b2", 32'(dec_b), 32'h2);
        chk("d1_step_b2", 32'(step_b), 32'd1);
        idle(1);
        chk("scan3_dec_a", 32'(dec_a), 32'h10);
        chk("scan3_step_a", 32'(step_a), 32'd1);
        idle(3);
        chk("wrap_dec_a", 32'(dec_a), 32'h01);
        chk("wrap_sel_a", 32'(cur_a), 32'd0);
        idle(3);
        chk("adv_sel_a", 32'(cur_a), 32'd1);

        drv(0, 1, 0, 3'd5);
        chk("coll_dec_a", 32'(dec_a), 32'd0);
        chk("coll_busy_a", 32'(busy_a), 32'd0);
        chk("coll_sel_a", 32'(cur_a), 32'd1);

        drv(1, 1, 0, 3'd6);
        chk("oor_dec_a", 32'(dec_a), 32'd0);
        chk("oor_busy_a", 32'(busy_a), 32'd1);
        chk("oor_sel_a", 32'(cur_a), 32'd6);
`ifdef DECODER_SCAN_ERR_EN
        chk("oor_err_a", 32'(err_a), 32'd1);
`endif
        drv(1, 1, 1, 3'd0);
`ifdef DECODER_SCAN_ERR_EN
        chk("oor_err_a_clr", 32'(err_a), 32'd0);
`endif
        idle(1);
        drv(1, 1, 1, 3'd1);
        chk("reload_dec_a", 32'(dec_a), 32'h02);
        chk("reload_step_a", 32'(step_a), 32'd0);
        idle(2);
        chk("reload_hold_a", 32'(dec_a), 32'h02);
        chk("reload_nostep_a", 32'(step_a), 32'd0);
        idle(1);
        chk("reload_adv_a", 32'(dec_a), 32'h04);
        chk("reload_step_a2", 32'(step_a), 32'd1);

        drv(1, 1, 1, 3'd7);
        chk("scan_oor_sel_a", 32'(cur_a), 32'd0);
        chk("scan_oor_dec_a", 32'(dec_a), 32'h01);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_dec_a", 32'(dec_a), 32'd0);
        chk("arst_busy_a", 32'(busy_a), 32'd0);
        chk("arst_dec_b", 32'(dec_b), 32'd0);
        chk("arst_step_b", 32'(step_b), 32'd0);
        @(negedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                @(posedge clk);
                #2 rst = 1'b1;
                #2 rst = 1'b0;
                @(negedge clk);
                #1;
            end
            drv($urandom_range(0, 15) != 0, $urandom_range(0, 5) == 0,
                1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decoder_scan.md
Name: decoder_scan

Overview:
- Parametrised, registered binary-to-one-hot decoder; successor to the team's 2-to-4 combinational decoder.
- Two modes:
  - Direct: latch a select code and decode it.
  - Scan: walk the one-hot output across all channels with a programmable dwell time.
- Sits between control logic and multiplexed loads (display digit enables, bank selects, row strobes).

Parameters:
- SEL_W, 2, width of select code.
- NUM_OUT, 4, number of one-hot outputs; must satisfy 2 <= NUM_OUT <= 2**SEL_W.
- DWELL, 4, clock cycles each output stays active in scan mode; must be >= 1.
- CNT_W, $clog2(DWELL+1), dwell counter width (derived; do not override).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  block enable; 0 forces outputs to zero and state to IDLE.
- mode  input  1  0 = direct, 1 = scan; sampled only in IDLE or on load.
- load  input  1  one-cycle strobe: capture sel_in (direct) or start scan.
- sel_in  input  SEL_W  select code.
- dec_out  output  NUM_OUT  registered one-hot output.
- sel_cur  output  SEL_W  code currently driven on dec_out.
- step  output  1  one-cycle pulse when scan advances to next channel.
- busy  output  1  high in DIRECT or SCAN state.

Behaviour:
- Reset (async assert, sync release): state = IDLE, dec_out = 0, sel_cur = 0, step = 0, busy = 0, dwell counter = 0.
- FSM states: IDLE, DIRECT, SCAN.
- IDLE:
  - On load & en & ~mode: capture sel_in and go to DIRECT.
  - On load & en & mode: go to SCAN. sel_cur = sel_in if sel_in < NUM_OUT, else 0. Dwell counter = 0.
- DIRECT:
  - dec_out = 1 << sel_cur, valid the cycle after load (latency 1).
  - A new load recaptures sel_in and may switch mode. A load with mode = 1 enters SCAN at sel_in, as above.
- SCAN:
  - Counter increments each cycle.
  - When counter == DWELL-1: counter clears, step = 1 for one cycle, sel_cur advances.
  - Advance wraps: sel_cur = 0 when sel_cur == NUM_OUT-1. This is a non-power-of-two wrap, not natural overflow.
  - A load during SCAN restarts the scan from the new sel_in with counter = 0; no step that cycle.
  - Scan runs indefinitely until en drops or a direct-mode load occurs.
- en = 0 in any state: next cycle state = IDLE, dec_out = 0, busy = 0, step = 0. sel_cur holds its value. en dominates a simultaneous load.
- Out-of-range code in DIRECT (sel_in >= NUM_OUT): dec_out = 0, sel_cur = sel_in, busy = 1.
- DWELL = 1: advance every cycle; step is high continuously while scanning.
- dec_out is always one-hot or zero, never multi-hot, including across mode switches.
- Reset mid-scan: immediate clear to reset values; no partial step pulse.

Optional Feature:
- Macro: DECODER_SCAN_ERR_EN.
- Defined:
  - Adds output err (1 bit), registered, reset 0.
  - err pulses for one cycle, the cycle after a load whose sel_in >= NUM_OUT. The code is still applied per the rules above.
- Undefined: no err port; out-of-range codes silently handled as above.

Decomposition:
- Shared package decoder_pkg:
  - State enum typedef (IDLE = 2'd0, DIRECT = 2'd1, SCAN = 2'd2).
  - MODE_DIRECT / MODE_SCAN constants.
- Sub-module: decoder_onehot. Purely combinational SEL_W to NUM_OUT decode with an out-of-range zero output. It is reused by decoder_scan and replaces the fixed 2-to-4 block in new designs.

Test Plan:
- Reset/direct, SEL_W=2, NUM_OUT=4: reset asserted mid-cycle -> all outputs 0 immediately. Then load, mode=0, sel_in=2 -> next cycle dec_out=4'b0100, sel_cur=2, busy=1.
- Scan wrap, SEL_W=3, NUM_OUT=5, DWELL=3: load, mode=1, sel_in=3 -> dec_out=8 for 3 cycles, step pulse, then 16, then 1. Wrap 4->0; 5-7 never appear.
- Out-of-range, SEL_W=3, NUM_OUT=5: direct load sel_in=6 -> dec_out=0, busy=1. With DECODER_SCAN_ERR_EN defined, err=1 for exactly one cycle.
- Enable/load collision: en=0 and load=1 in the same cycle during SCAN -> IDLE next cycle, dec_out=0, sel_cur unchanged.
- Reload mid-scan, DWELL=4: load sel_in=1 on dwell count 2 -> dec_out=2 next cycle; dwell restarts; first step 4 cycles later.
- DWELL=1, NUM_OUT=4: scan from 0 -> dec_out rotates 1,2,4,8,1 every cycle; step high continuously. Checker asserts one-hot-or-zero every cycle.
